// File: rtl/prio_enc_scan7.sv
// Priority/one-hot encoder of a request vector, shown as hex on a
// multiplexed seven-segment display scanned at one digit per SCAN_DIV cycles.
module prio_enc_scan7 #(
  parameter int IN_W     = 16,
  parameter int N_DIG    = 8,
  parameter int SCAN_DIV = 100000,
  parameter int PRIO     = 1,
  localparam int IDX_W   = $clog2(IN_W),
  localparam int NIB     = (IDX_W + 3) / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btnD,
  input  logic [IN_W-1:0]  sw,
  output logic [IDX_W-1:0] led,
  output logic             valid,
  output logic             err,
  output logic [N_DIG-1:0] sel_seg,
  output logic [6:0]       seg
);

  localparam int  CNT_W    = $clog2(SCAN_DIV);
  localparam int  PTR_W    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam bit  ONE_HOT  = (PRIO == 0);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  if (NIB > N_DIG) begin : g_nib_check
    $error("prio_enc_scan7: index needs more hex digits than N_DIG provides");
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [IDX_W-1:0] led_r, enc_idx_s, led_n_s;
  logic             valid_r, err_r, en_r, valid_n_s, err_n_s;
  logic             any_s, multi_s;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] ptr_r;
  logic [NIB*4-1:0] led_ext_s;
  logic [3:0]       nib_s;
  logic [N_DIG-1:0] sel_seg_s;
  logic [6:0]       seg_s;

  // encode the live request; the scan from bit 0 upward leaves the highest set bit
  always_comb begin
    enc_idx_s = '0;
    for (int i = 0; i < IN_W; i++) begin
      enc_idx_s = sw[i] ? IDX_W'(i) : enc_idx_s;
    end
    any_s   = |sw;
    multi_s = ($countones(sw) > 32'sd1);
    if (!btnD || !any_s) begin
      led_n_s   = '0;
      valid_n_s = 1'b0;
      err_n_s   = 1'b0;
    end else if (ONE_HOT && multi_s) begin
      led_n_s   = '0;
      valid_n_s = 1'b0;
      err_n_s   = 1'b1;
    end else begin
      led_n_s   = enc_idx_s;
      valid_n_s = 1'b1;
      err_n_s   = 1'b0;
    end
  end

  // sampled result registers and the free-running scan timebase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_r    <= 1'b0;
      led_r   <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
      ptr_r   <= '0;
    end else begin
      en_r    <= btnD;
      led_r   <= led_n_s;
      valid_r <= valid_n_s;
      err_r   <= err_n_s;
      if (cnt_r == CNT_W'(SCAN_DIV - 1)) begin
        cnt_r <= '0;
        ptr_r <= (ptr_r == PTR_W'(N_DIG - 1)) ? '0 : ptr_r + PTR_W'(1);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
        ptr_r <= ptr_r;
      end
    end
  end

  // digit select and segment pattern, decoded purely from registered state
  always_comb begin
    led_ext_s = (NIB*4)'(led_r);
    nib_s     = 4'(led_ext_s >> {ptr_r, 2'b00});
    sel_seg_s = '1;
    seg_s     = BLANK;
    if (en_r) begin
      sel_seg_s = ~(N_DIG'(1'b1) << ptr_r);
      if (valid_r && (int'(ptr_r) < NIB)) begin
        seg_s = hex7(nib_s);
      end else if (err_r && (ptr_r == '0)) begin
        seg_s = DASH;
      end else begin
        seg_s = BLANK;
      end
    end else begin
      sel_seg_s = '1;
      seg_s     = BLANK;
    end
  end

  assign led     = led_r;
  assign valid   = valid_r;
  assign err     = err_r;
  assign sel_seg = sel_seg_s;
  assign seg     = seg_s;

endmodule
